wave_display: RTL and testbench

- Downstream consumer of the wave capture stage's sample RAM (512 x 8, two 256-entry halves selected by address bit 8).
- Scans the half named by read_index in step with the VGA pixel stream and draws the captured waveform as a connected white trace.
- Signals the capture stage through wave_display_idle when the display is outside its drawing region, so the capture stage may swap buffers.

---
 rtl/wave_display.sv | 128 ++++++++++++
 tb/tb_wave_display.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/wave_display.sv
// rtl/wave_display.sv - draws the captured sample RAM half as a connected trace in the VGA pixel stream
module wave_display #(
   parameter int ADDR_WIDTH   = 9,
   parameter int SAMPLE_WIDTH = 8,
   parameter int X_WIDTH      = 11,
   parameter int Y_WIDTH      = 10
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [X_WIDTH-1:0]      x,
   input  logic [Y_WIDTH-1:0]      y,
   input  logic                    valid,
   input  logic                    read_index,
   output logic [ADDR_WIDTH-1:0]   read_address,
   input  logic [SAMPLE_WIDTH-1:0] read_value,
   output logic                    valid_pixel,
   output logic [7:0]              r,
   output logic [7:0]              g,
   output logic [7:0]              b,
   output logic                    wave_display_idle
);

   typedef enum logic [1:0] {WAIT_FRAME, DRAW, IDLE} state_t;

   state_t      state_q, state_d;
   logic        disp_index_q, disp_index_d;
   logic        idle_q, idle_d;
   logic        s1_valid_q, s1_valid_d;
   logic        s1_region_q, s1_region_d;
   logic [7:0]  s1_level_q, s1_level_d;
   logic        s1_col_change_q, s1_col_change_d;
   logic        s1_first_col_q, s1_first_col_d;
   logic [7:0]  col_last_q, col_last_d;
   logic [7:0]  cur_last_q, cur_last_d;
   logic [7:0]  prev_q, prev_d;
   logic        valid_pixel_q, valid_pixel_d;
   logic [7:0]  rgb_q, rgb_d;

   logic        frame_start;
   logic [7:0]  col;
   logic [7:0]  cur, lo, hi;
   logic        lit;

   assign col          = x[8:1];
   assign read_address = {disp_index_q, col};
   assign frame_start  = valid && (x == '0) && (y == '0);

   always_comb begin
      state_d      = state_q;
      disp_index_d = disp_index_q;
      case (state_q)
         DRAW: begin
            if (valid && (y == Y_WIDTH'(512))) state_d = IDLE;
         end
         default: begin
            if (frame_start) begin
               state_d      = DRAW;
               disp_index_d = read_index;
            end
         end
      endcase
      idle_d = (state_d == IDLE);

      // Stage 1: pixel bookkeeping while the RAM read is in flight
      s1_valid_d      = valid;
      s1_region_d     = (x[10:9] == 2'b01) && !y[9] && (state_q == DRAW);
      s1_level_d      = 8'd255 - y[8:1];
      s1_col_change_d = (col != col_last_q);
      s1_first_col_d  = (col == 8'd0);
      col_last_d      = col;

      // Stage 2: the first column never links back to the previous frame's last sample
      cur        = read_value;
      cur_last_d = cur;
      if (s1_first_col_q)
         prev_d = cur;
      else if (s1_col_change_q)
         prev_d = cur_last_q;
      else
         prev_d = prev_q;

      lo  = (prev_d < cur) ? prev_d : cur;
      hi  = (prev_d < cur) ? cur : prev_d;
      lit = (lo <= s1_level_q) && (s1_level_q <= hi);

      valid_pixel_d = s1_valid_q && s1_region_q;
      rgb_d         = (valid_pixel_d && lit) ? 8'hFF : 8'h00;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= WAIT_FRAME;
         disp_index_q    <= 1'b0;
         idle_q          <= 1'b0;
         s1_valid_q      <= 1'b0;
         s1_region_q     <= 1'b0;
         s1_level_q      <= 8'd0;
         s1_col_change_q <= 1'b0;
         s1_first_col_q  <= 1'b0;
         col_last_q      <= 8'd0;
         cur_last_q      <= 8'd0;
         prev_q          <= 8'd0;
         valid_pixel_q   <= 1'b0;
         rgb_q           <= 8'd0;
      end else begin
         state_q         <= state_d;
         disp_index_q    <= disp_index_d;
         idle_q          <= idle_d;
         s1_valid_q      <= s1_valid_d;
         s1_region_q     <= s1_region_d;
         s1_level_q      <= s1_level_d;
         s1_col_change_q <= s1_col_change_d;
         s1_first_col_q  <= s1_first_col_d;
         col_last_q      <= col_last_d;
         cur_last_q      <= cur_last_d;
         prev_q          <= prev_d;
         valid_pixel_q   <= valid_pixel_d;
         rgb_q           <= rgb_d;
      end
   end

   assign valid_pixel       = valid_pixel_q;
   assign r                 = rgb_q;
   assign g                 = rgb_q;
   assign b                 = rgb_q;
   assign wave_display_idle = idle_q;

endmodule

// File: tb/tb_wave_display.sv
// tb/tb_wave_display.sv - randomized scoreboard bench for wave_display
module tb_wave_display;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [10:0] x = '0;
   logic [9:0]  y = '0;
   logic        valid = 1'b0;
   logic        read_index = 1'b0;
   logic [8:0]  read_address;
   logic [7:0]  read_value = '0;
   logic        valid_pixel;
   logic [7:0]  r, g, b;
   logic        wave_display_idle;

   wave_display dut (
      .clk(clk), .reset(reset), .x(x), .y(y), .valid(valid),
      .read_index(read_index), .read_address(read_address), .read_value(read_value),
      .valid_pixel(valid_pixel), .r(r), .g(g), .b(b),
      .wave_display_idle(wave_display_idle)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] mem [512];
   always @(posedge clk) read_value <= mem[read_address];

   typedef struct {
      int       stamp;
      bit       vp;
      bit [7:0] px;
   } exp_t;
   exp_t sb[$];

   int n_cmp = 0;
   int n_err = 0;

   // Reference: 0 = waiting for frame, 1 = drawing, 2 = idle
   int m_state = 0;
   bit m_disp  = 1'b0;
   bit have_prev = 1'b0;

   function automatic bit trace_lit(int col, int lvl);
      int base, cur, prv, lo, hi;
      base = m_disp ? 256 : 0;
      cur  = int'(mem[base + col]);
      prv  = (col == 0) ? cur : int'(mem[base + col - 1]);
      lo   = (prv < cur) ? prv : cur;
      hi   = (prv < cur) ? cur : prv;
      return (lo <= lvl) && (lvl <= hi);
   endfunction

   task automatic pix(input int px, input int py, input bit v, input bit rst);
      exp_t e;
      logic [8:0] exp_addr;
      bit in_reg;
      @(posedge clk);
      #1;
      if (have_prev) begin
         n_cmp++;
         if (wave_display_idle !== (m_state == 2)) begin
            n_err++;
            $display("FAIL idle at x=%0d y=%0d: got %b want %b", x, y, wave_display_idle, m_state == 2);
         end
      end
      reset = rst;
      x     = 11'(px);
      y     = 10'(py);
      valid = v;
      #1;
      exp_addr = {m_disp, x[8:1]};
      n_cmp++;
      if (read_address !== exp_addr) begin
         n_err++;
         $display("FAIL read_address at x=%0d y=%0d: got %h want %h", px, py, read_address, exp_addr);
      end
      in_reg  = (px >= 512) && (px <= 1023) && (py < 512);
      e.stamp = cyc + 2;
      e.vp    = !rst && v && (m_state == 1) && in_reg;
      e.px    = (e.vp && trace_lit(px / 2 % 256, 255 - (py / 2 % 256))) ? 8'hFF : 8'h00;
      sb.push_back(e);
      if (rst) begin
         m_state = 0;
         m_disp  = 1'b0;
      end else if (v) begin
         if (m_state != 1 && px == 0 && py == 0) begin
            m_state = 1;
            m_disp  = read_index;
         end else if (m_state == 1 && py == 512) begin
            m_state = 2;
         end
      end
      have_prev = 1'b1;
   endtask

   task automatic do_frame(input int f);
      int rows[8];
      for (int i = 0; i < 512; i++) mem[i] = 8'($urandom_range(255));
      if (f == 0) begin
         mem[4]   = 8'd190;
         mem[5]   = 8'd200;
         mem[0]   = 8'd50;
         mem[255] = 8'd250;
      end
      read_index = (f == 1) || (f == 4);
      rows = '{90, 110, 130, 300, 410, 411, 0, 0};
      rows[6] = int'($urandom_range(1, 511));
      rows[7] = int'($urandom_range(1, 511));
      pix(0, 0, 1'b1, 1'b0);
      for (int ri = 0; ri < 8; ri++) begin
         if (f == 3 && rows[ri] == 300) pix(0, 300, 1'b1, 1'b1);
         if (f == 1 && ri == 2) read_index = 1'b0;
         for (int px = 508; px < 1028; px++)
            pix(px, rows[ri], ($urandom_range(7) != 0), 1'b0);
      end
      pix(0, 512, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) pix(600 + i, 700, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) pix(1020 + i, 1023, 1'b1, 1'b0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].stamp <= cyc) begin
            e = sb.pop_front();
            n_cmp++;
            if (e.stamp != cyc || valid_pixel !== e.vp || r !== e.px || g !== e.px || b !== e.px) begin
               n_err++;
               $display("FAIL pixel stamp=%0d cyc=%0d: got vp=%b rgb=%h/%h/%h want vp=%b rgb=%h",
                        e.stamp, cyc, valid_pixel, r, g, b, e.vp, e.px);
            end
         end
      end
   end

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
      $fatal(1);
   end

   initial begin : stim
      for (int i = 0; i < 512; i++) mem[i] = 8'd0;
      for (int i = 0; i < 3; i++) pix(0, 0, 1'b1, 1'b1);
      for (int f = 0; f < 5; f++) do_frame(f);
      repeat (4) @(posedge clk);
      #2;
      n_cmp++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard drain: got %0d pending want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
